// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Opcodes, flag bit positions, skid buffer state encoding, flag vector width.
// Optional feature macro: ALU_PARITY_FLAG_EN (adds P flag as flags[4]).
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;
    localparam int FLG_P = 4;

`ifdef ALU_PARITY_FLAG_EN
    localparam int FLAGS_W = 5;
`else
    localparam int FLAGS_W = 4;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready buffer (main + skid entry), payload width DW.
// Latency 1 cycle from accept to o_valid; full throughput when downstream is ready.
// o_in_ready is a flop (no comb path from i_out_ready); deasserts only when both entries hold data.
// Ports: clk, rst (sync, active-high), i_valid/o_in_ready/i_dat upstream,
//        o_valid/i_out_ready/o_dat downstream.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_dat,
    output logic          o_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_dat
);

    buf_state_e    r_state;
    buf_state_e    w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          w_acc;
    logic          w_emit;

    assign w_acc  = i_valid && r_in_ready;
    assign w_emit = r_out_valid && i_out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_main_nxt  = i_dat;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_acc && w_emit) begin
                    w_main_nxt = i_dat;
                end else if (w_emit) begin
                    w_state_nxt = EMPTY;
                end else if (w_acc) begin
                    // Main is stalled at the output; park the new beat behind it.
                    w_skid_nxt  = i_dat;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                // in_ready is low here, so only an emit can occur.
                if (w_emit) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            // Handshake outputs are registered copies of the next-state decode.
            r_out_valid <= (w_state_nxt != EMPTY);
            r_in_ready  <= (w_state_nxt != FULL);
        end
    end

    assign o_valid    = r_out_valid;
    assign o_in_ready = r_in_ready;
    assign o_dat      = r_main;

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: selects unit result by opcode, computes {P,}V,C,N,Z, counts emitted beats.
// Latency 1 cycle (accept edge -> result/flags valid); registered outputs.
// Backpressure absorbed by a 2-entry skid buffer; in_ready drops only when both entries are full.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, op, a, b, and_res/or_res/add_res/sub_res,
//        add_co, sub_bo upstream; out_valid/out_ready, result, flags, xfer_cnt downstream.
// Macro ALU_PARITY_FLAG_EN: when defined, flags grows to 5 bits with P = ^result at flags[4].
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [W-1:0]       and_res,
    input  logic [W-1:0]       or_res,
    input  logic [W-1:0]       add_res,
    input  logic [W-1:0]       sub_res,
    input  logic               add_co,
    input  logic               sub_bo,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       result,
    output logic [FLAGS_W-1:0] flags,
    output logic [15:0]        xfer_cnt
);

    logic [W-1:0]         w_result;
    logic [FLAGS_W-1:0]   w_flags;
    logic [FLAGS_W+W-1:0] w_buf_out;
    logic                 w_out_valid;
    logic [15:0]          r_xfer_cnt;

    always_comb begin
        w_result = '0;
        w_flags  = '0;
        case (op_e'(op))
            OP_AND: w_result = and_res;
            OP_OR:  w_result = or_res;
            OP_ADD: begin
                w_result       = add_res;
                w_flags[FLG_C] = add_co;
                // Same-sign operands producing an opposite-sign sum.
                w_flags[FLG_V] = (a[W-1] == b[W-1]) && (add_res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                w_result       = sub_res;
                w_flags[FLG_C] = sub_bo;
                // Opposite-sign operands where the difference takes b's sign.
                w_flags[FLG_V] = (a[W-1] != b[W-1]) && (sub_res[W-1] != a[W-1]);
            end
            default: w_result = '0;
        endcase
        w_flags[FLG_Z] = (w_result == '0);
        w_flags[FLG_N] = w_result[W-1];
`ifdef ALU_PARITY_FLAG_EN
        w_flags[FLG_P] = ^w_result;
`endif
    end

    alu_skid_buffer #(
        .DW (FLAGS_W + W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (in_valid),
        .o_in_ready  (in_ready),
        .i_dat       ({w_flags, w_result}),
        .o_valid     (w_out_valid),
        .i_out_ready (out_ready),
        .o_dat       (w_buf_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign out_valid = w_out_valid;
    assign result    = w_buf_out[W-1:0];
    assign flags     = w_buf_out[FLAGS_W+W-1:W];
    assign xfer_cnt  = r_xfer_cnt;

endmodule
